ir_sense_seq: RTL

Sequencer that owns the IR emitter enables and the shared A2D converter for one line-sensor sweep. On `go` it steps through the inner, middle and outer emitter pairs. For each pair it waits a settle time, then converts the right and left channels. It folds each pair's result into a signed weighted steering error. It sits between the A2D interface (`start_conv`/`cnv_cmplt`/`A2D_res`/`chnnl`) and the motion controller, which consumes `error` when `done` pulses.

---
 rtl/ir_sense_pkg.sv | 62 ++++++
 rtl/ir_settle_cnt.sv | 29 ++
 rtl/ir_sense_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ir_sense_pkg.sv
// ir_sense_pkg: shared types and constants for the IR line-sensor sweep.
// Sweep states, emitter-pair channel map, pair weights, watchdog limit.
package ir_sense_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CONV_R = 3'd2,
    WAIT_R = 3'd3,
    CONV_L = 3'd4,
    WAIT_L = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [2:0] CH_IN_R  = 3'd1;
  localparam logic [2:0] CH_IN_L  = 3'd0;
  localparam logic [2:0] CH_MID_R = 3'd4;
  localparam logic [2:0] CH_MID_L = 3'd2;
  localparam logic [2:0] CH_OUT_R = 3'd3;
  localparam logic [2:0] CH_OUT_L = 3'd7;

  // Weights are powers of two: 1, 2, 4.
  localparam logic [1:0] WSH_IN  = 2'd0;
  localparam logic [1:0] WSH_MID = 2'd1;
  localparam logic [1:0] WSH_OUT = 2'd2;

  localparam int A2D_TIMEOUT = 1024;

  function automatic logic [2:0] ch_r(input logic [1:0] p);
    case (p)
      2'd0:    ch_r = CH_IN_R;
      2'd1:    ch_r = CH_MID_R;
      default: ch_r = CH_OUT_R;
    endcase
  endfunction

  function automatic logic [2:0] ch_l(input logic [1:0] p);
    case (p)
      2'd0:    ch_l = CH_IN_L;
      2'd1:    ch_l = CH_MID_L;
      default: ch_l = CH_OUT_L;
    endcase
  endfunction

  function automatic logic [1:0] wsh(input logic [1:0] p);
    case (p)
      2'd0:    wsh = WSH_IN;
      2'd1:    wsh = WSH_MID;
      default: wsh = WSH_OUT;
    endcase
  endfunction

  // One-hot emitter enables ordered {out, mid, in}.
  function automatic logic [2:0] emit(input logic [1:0] p);
    case (p)
      2'd0:    emit = 3'b001;
      2'd1:    emit = 3'b010;
      default: emit = 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/ir_settle_cnt.sv
// ir_settle_cnt: clear/enable up-counter with terminal-count flag.
// Times emitter settling and, optionally, the converter watchdog.
module ir_settle_cnt #(
  parameter int W     = 13,
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  // count enabled cycles since the last clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(LIMIT));

endmodule

// File: rtl/ir_sense_seq.sv
// ir_sense_seq: IR emitter / A2D sequencer for one line-sensor sweep.
// Optional converter watchdog and a2d_to port: IR_SENSE_TIMEOUT_EN.
module ir_sense_seq
  import ir_sense_pkg::*;
#(
  parameter int SETTLE_CYC = 4096,
  parameter int CNT_W      = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               cnv_cmplt,
  input  logic [11:0]        A2D_res,
  output logic               start_conv,
  output logic [2:0]         chnnl,
  output logic               IR_in_en,
  output logic               IR_mid_en,
  output logic               IR_out_en,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] error
`ifdef IR_SENSE_TIMEOUT_EN
  ,
  output logic               a2d_to
`endif
);

  state_t             state;
  logic [1:0]         pair;
  logic signed [15:0] acc;
  logic signed [15:0] term;
  logic               settle_tc;
  logic               to_hit;

  assign term = $signed({4'd0, A2D_res} << wsh(pair));

  ir_settle_cnt #(
    .W    (CNT_W),
    .LIMIT(SETTLE_CYC)
  ) u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != SETTLE),
    .en   ((state == SETTLE) && !settle_tc),
    .tc   (settle_tc)
  );

`ifdef IR_SENSE_TIMEOUT_EN
  logic waiting;
  logic wd_tc;

  assign waiting = (state == WAIT_R) || (state == WAIT_L);

  // Limit is two short so done lands A2D_TIMEOUT cycles after start_conv.
  ir_settle_cnt #(
    .W    (11),
    .LIMIT(A2D_TIMEOUT - 2)
  ) u_wdog (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!waiting),
    .en   (waiting && !wd_tc),
    .tc   (wd_tc)
  );

  // a conversion arriving on the limit cycle still wins
  assign to_hit = waiting && wd_tc && !cnv_cmplt;
`else
  assign to_hit = 1'b0;
`endif

  // sweep sequencer: emitters, conversions, weighted accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pair       <= 2'd0;
      acc        <= '0;
      error      <= '0;
      start_conv <= 1'b0;
      chnnl      <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      {IR_out_en, IR_mid_en, IR_in_en} <= 3'b000;
`ifdef IR_SENSE_TIMEOUT_EN
      a2d_to     <= 1'b0;
`endif
    end else begin
      start_conv <= 1'b0;
      done       <= 1'b0;
      if (to_hit) begin
`ifdef IR_SENSE_TIMEOUT_EN
        a2d_to <= 1'b1;
`endif
        done  <= 1'b1;
        busy  <= 1'b0;
        chnnl <= 3'd0;
        {IR_out_en, IR_mid_en, IR_in_en} <= 3'b000;
        state <= DONE;
      end else begin
        unique case (state)
          IDLE: begin
            if (go) begin
              acc   <= '0;
              pair  <= 2'd0;
              busy  <= 1'b1;
              {IR_out_en, IR_mid_en, IR_in_en} <= emit(2'd0);
              state <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_tc) begin
              start_conv <= 1'b1;
              chnnl      <= ch_r(pair);
              state      <= CONV_R;
            end
          end
          CONV_R: state <= WAIT_R;
          WAIT_R: begin
            if (cnv_cmplt) begin
              acc        <= acc + term;
              start_conv <= 1'b1;
              chnnl      <= ch_l(pair);
              state      <= CONV_L;
            end
          end
          CONV_L: state <= WAIT_L;
          WAIT_L: begin
            if (cnv_cmplt) begin
              acc <= acc - term;
              if (pair < 2'd2) begin
                pair  <= pair + 2'd1;
                {IR_out_en, IR_mid_en, IR_in_en} <= emit(pair + 2'd1);
                state <= SETTLE;
              end else begin
                error <= acc - term;
                done  <= 1'b1;
                busy  <= 1'b0;
                chnnl <= 3'd0;
                {IR_out_en, IR_mid_en, IR_in_en} <= 3'b000;
                state <= DONE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
